mem_responder: RTL
==================

# mem_responder

Word-addressed memory responder serving the datapath's MAR/MDR pair. It accepts a read or write request using the MAR address and MDR write data. After a programmable wait it completes with a one-cycle `mem_done` pulse. For reads, it returns the word on `mdata_out`, which drives the MDR's memory-side data input (`mdata_in`) for capture on `MDRin`.

## Interface
Parameters:
- `ADDR_W`, 9: index width of the word array.
- `DEPTH`, 512: number of 32-bit words; must be ≤ 2**`ADDR_W`.
- `LATENCY`, 2: extra wait cycles between request accept and completion; legal range 0–15.

Ports:
- `clock`: input, 1 bit. Single clock; all state changes on its rising edge.
- `reset`: input, 1 bit. Synchronous, active-high reset.
- `address`: input, 32 bits. Word address from MAR output.
- `write_data`: input, 32 bits. Store data from MDR output.
- `read`: input, 1 bit. Read request level.
- `write`: input, 1 bit. Write request level.
- `mdata_out`: output, 32 bits. Read data, held until the next read completes. Feeds MDR `mdata_in`.
- `mem_done`: output, 1 bit. One-cycle completion pulse.
- `busy`: output, 1 bit. High whenever a request is in progress (state ≠ IDLE).
- `mem_err`: output, 1 bit. Out-of-range flag. Present only with `MEM_OOR_ERR_EN`.

## Operation
State machine states: IDLE, WAIT, DONE.
- **IDLE**
  - `read` or `write` high at an edge → latch `address`, `write_data` and op; load `cnt` ← `LATENCY`; go to WAIT.
  - `read` and `write` both high → treated as a write.
- **WAIT**
  - `cnt` = 0 → go to DONE. The array access happens on this same edge: write commits to the array, or read data loads `mdata_out`.
  - Otherwise `cnt` ← `cnt` − 1.
- **DONE**
  - `mem_done` = 1 for this one cycle; go to IDLE on the next edge.
- Requests are sampled only in IDLE. `read`/`write` in WAIT/DONE are ignored; they are not queued.
- Index computation: array index is `address[ADDR_W-1:0]`. Upper address bits are ignored unless `MEM_OOR_ERR_EN` is defined.
- Write completion leaves `mdata_out` unchanged.
- Array contents are not initialised by reset. Contents survive reset.

## Timing
- Request sampled at edge k.
- `mem_done` is high between edges k+`LATENCY`+1 and k+`LATENCY`+2.
- For a read, `mdata_out` is valid from edge k+`LATENCY`+1 onward.
- Earliest next request accept: edge k+`LATENCY`+3. `busy` is low in that cycle.
- Read immediately after a write to the same address returns the new data.
- Reset values: state IDLE, `cnt` 0, `mdata_out` 0, `mem_done` 0, `busy` 0, `mem_err` 0.
- Reset asserted mid-request (WAIT or DONE):
  - Request is abandoned and no `mem_done` pulse is produced.
  - A write still in WAIT is not committed.
  - Reset has priority over every other event at the same edge.

## Configuration
- `MEM_OOR_ERR_EN` defined:
  - `mem_err` port exists.
  - An accepted request with `address` ≥ `DEPTH` still completes normally in timing, with `mem_done` pulsing.
  - `mem_err` = 1 in the DONE cycle.
  - The write is suppressed.
  - A read loads `mdata_out` with 0.
- `MEM_OOR_ERR_EN` undefined:
  - No `mem_err` port.
  - Address wraps modulo 2**`ADDR_W` through the index truncation.

## Structure
- Package `mem_pkg`: `DATA_W` = 32, state enum `mem_state_t` {IDLE, WAIT, DONE}, `LAT_W` = 4.
- Sub-module `mem_array`: single-port synchronous RAM, `DEPTH` × `DATA_W`. Inputs: write enable, index, write data. Output: registered read data, no read-during-write hazard handling needed. `mem_responder` holds the FSM, `cnt`, and the request latches.

## Test plan
- **Reset**: hold `reset` 2 cycles → all outputs 0, `busy` 0.
- **Write then read**, `LATENCY`=2:
  - Write 0xDEADBEEF to address 5 at edge k → `mem_done` pulse at k+3.
  - Read address 5 → `mdata_out` = 0xDEADBEEF at k'+3, `mem_done` exactly 1 cycle wide.
- **`LATENCY`=0**: read of address 7 after writing 0x12345678 → `mem_done` at k+1 with data correct.
- **Ignored request**: pulse `write` of 0xFFFFFFFF to address 5 during WAIT of an active read → array unchanged; a following read of 5 returns the old data.
- **Reset mid-write**: assert `reset` at k+1 of a write of 0xA5A5A5A5 to address 9 → no `mem_done`; reading address 9 returns its prior value.
- **Address ≥ `DEPTH`** (`DEPTH`=512):
  - With `MEM_OOR_ERR_EN`: read address 600 → `mem_err`=1 with `mem_done`, `mdata_out`=0; write to 600 leaves address 88 unchanged.
  - Without the macro: write to 600 aliases to address 88 (600 mod 512).

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared widths and FSM state type for mem_responder and mem_array
package mem_pkg;
  localparam int DATA_W = 32;
  localparam int LAT_W  = 4;
  typedef enum logic [1:0] {IDLE, WAIT, DONE} mem_state_t;
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port synchronous word RAM with registered read data
// Ports: clock, we (write enable), idx (word index), wdata (store data), rdata (registered read of idx)
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clock) begin
    if (we) mem_q[idx] <= wdata;
    rdata <= mem_q[idx];
  end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR memory responder with programmable wait and one-cycle completion pulse
// Ports: clock, reset (sync, active-high), address/write_data/read/write (request),
//        mdata_out (read data to MDR), mem_done (completion pulse), busy (request in flight),
//        mem_err (out-of-range flag, only when MEM_OOR_ERR_EN is defined)
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 9,
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic [31:0]       write_data,
  input  logic              read,
  input  logic              write,
  output logic [DATA_W-1:0] mdata_out,
  output logic              mem_done,
  output logic              busy
`ifdef MEM_OOR_ERR_EN
  ,
  output logic              mem_err
`endif
);
  mem_state_t        state_q;
  logic [LAT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] idx_q;
  logic [DATA_W-1:0] wdata_q, hold_q, rdata;
  logic              wr_q, oor_q, oor_d, we;
`ifdef MEM_OOR_ERR_EN
  assign oor_d   = address >= 32'(DEPTH);
  assign mem_err = (state_q == DONE) && oor_q;
`else
  logic unused_addr;
  assign oor_d       = 1'b0;
  assign unused_addr = ^address[31:ADDR_W];
`endif
  // reset gates the commit so an abandoned write never lands in the array
  assign we        = (state_q == WAIT) && (cnt_q == '0) && wr_q && !oor_q && !reset;
  assign busy      = state_q != IDLE;
  assign mem_done  = state_q == DONE;
  // array read register is valid in DONE; hold_q keeps it until the next read completes
  assign mdata_out = (mem_done && !wr_q) ? (oor_q ? '0 : rdata) : hold_q;
  mem_array #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_array (
    .clock (clock),
    .we    (we),
    .idx   (idx_q),
    .wdata (wdata_q),
    .rdata (rdata)
  );
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hold_q  <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (read || write) begin
          state_q <= WAIT;
          cnt_q   <= LAT_W'(LATENCY);
          idx_q   <= address[ADDR_W-1:0];
          wdata_q <= write_data;
          wr_q    <= write;
          oor_q   <= oor_d;
        end
        WAIT: if (cnt_q == '0) state_q <= DONE;
              else cnt_q <= cnt_q - 1'b1;
        DONE: begin
          state_q <= IDLE;
          hold_q  <= mdata_out;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
